// File: rtl/inst_fifo.sv
// Dual-push / dual-pop instruction queue between fetch and decode, head and head+1 visible combinationally.
// Optional performance counters are built only when INST_FIFO_PERF_CNT_EN is defined.
module inst_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     fetch_valid0,
    input  logic                     fetch_valid1,
    input  logic [31:0]              fetch_pc0,
    input  logic [31:0]              fetch_pc1,
    input  logic [31:0]              fetch_inst0,
    input  logic [31:0]              fetch_inst1,
    output logic                     full_stall,
    output logic                     master_valid,
    output logic                     slave_valid,
    output logic [31:0]              master_pc,
    output logic [31:0]              master_inst,
    output logic [31:0]              slave_pc,
    output logic [31:0]              slave_inst,
    input  logic                     pop_master,
    input  logic                     pop_slave,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              perf_full_cycles,
    output logic [31:0]              perf_empty_cycles
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic [AW-1:0] head_reg, head_next;
    logic [AW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;

    logic          push0, push1, pop0, pop1;
    logic [CW-1:0] push_cnt, pop_cnt;
    logic [AW-1:0] tail_p1, head_p1;

    assign tail_p1 = tail_reg + 1'b1;
    assign head_p1 = head_reg + 1'b1;

    always_comb begin
        full_stall   = (count_reg > CW'(DEPTH - 2));
        master_valid = (count_reg >= CW'(1));
        slave_valid  = (count_reg >= CW'(2));

        // Stall guarantees two free slots, so an accepted pair never overruns head.
        push0 = fetch_valid0 && !full_stall;
        push1 = push0 && fetch_valid1;
        // Pops are judged against occupancy before this cycle's pushes land.
        pop0  = pop_master && master_valid;
        pop1  = pop0 && pop_slave && slave_valid;

        push_cnt = CW'(push0) + CW'(push1);
        pop_cnt  = CW'(pop0) + CW'(pop1);

        head_next  = head_reg + AW'(pop_cnt);
        tail_next  = tail_reg + AW'(push_cnt);
        count_next = count_reg + push_cnt - pop_cnt;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Storage is left uninitialised; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (resetn && !flush) begin
            if (push0) begin
                pc_mem[tail_reg]   <= fetch_pc0;
                inst_mem[tail_reg] <= fetch_inst0;
            end
            if (push1) begin
                pc_mem[tail_p1]    <= fetch_pc1;
                inst_mem[tail_p1]  <= fetch_inst1;
            end
        end
    end

    always_comb begin
        master_pc   = master_valid ? pc_mem[head_reg]   : 32'h0;
        master_inst = master_valid ? inst_mem[head_reg] : 32'h0;
        slave_pc    = slave_valid  ? pc_mem[head_p1]    : 32'h0;
        slave_inst  = slave_valid  ? inst_mem[head_p1]  : 32'h0;
    end

    assign count = count_reg;

`ifdef INST_FIFO_PERF_CNT_EN
    logic [31:0] perf_full_reg;
    logic [31:0] perf_empty_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_full_reg  <= '0;
            perf_empty_reg <= '0;
        end else begin
            if (full_stall && perf_full_reg != 32'hFFFF_FFFF)
                perf_full_reg <= perf_full_reg + 32'd1;
            if (count_reg == '0 && !flush && perf_empty_reg != 32'hFFFF_FFFF)
                perf_empty_reg <= perf_empty_reg + 32'd1;
        end
    end

    assign perf_full_cycles  = perf_full_reg;
    assign perf_empty_cycles = perf_empty_reg;
`else
    assign perf_full_cycles  = 32'h0;
    assign perf_empty_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// Directed bench for inst_fifo (DEPTH=16): reset, push/pop, stall, wrap, flush and reset-dominance.
module tb_inst_fifo;
    logic        clk = 1'b0;
    logic        resetn, flush;
    logic        fetch_valid0, fetch_valid1;
    logic [31:0] fetch_pc0, fetch_pc1, fetch_inst0, fetch_inst1;
    logic        full_stall, master_valid, slave_valid;
    logic [31:0] master_pc, master_inst, slave_pc, slave_inst;
    logic        pop_master, pop_slave;
    logic [4:0]  count;
    logic [31:0] perf_full_cycles, perf_empty_cycles;

    int tests = 0;
    int fails = 0;
    int wr_k  = 0;
    int rd_k  = 0;

    inst_fifo #(.DEPTH(16)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .fetch_valid0(fetch_valid0), .fetch_valid1(fetch_valid1),
        .fetch_pc0(fetch_pc0), .fetch_pc1(fetch_pc1),
        .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
        .full_stall(full_stall), .master_valid(master_valid), .slave_valid(slave_valid),
        .master_pc(master_pc), .master_inst(master_inst),
        .slave_pc(slave_pc), .slave_inst(slave_inst),
        .pop_master(pop_master), .pop_slave(pop_slave),
        .count(count),
        .perf_full_cycles(perf_full_cycles), .perf_empty_cycles(perf_empty_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pc_of(input int k);
        return 32'h100 + 32'(4 * k);
    endfunction

    function automatic logic [31:0] inst_of(input int k);
        return 32'hA + 32'(k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic drive(input int npush, input logic pm, input logic ps, input logic fl);
        fetch_valid0 = (npush >= 1);
        fetch_valid1 = (npush >= 2);
        fetch_pc0    = pc_of(wr_k);
        fetch_inst0  = inst_of(wr_k);
        fetch_pc1    = pc_of(wr_k + 1);
        fetch_inst1  = inst_of(wr_k + 1);
        pop_master   = pm;
        pop_slave    = ps;
        flush        = fl;
        @(posedge clk);
        #1;
        fetch_valid0 = 1'b0;
        fetch_valid1 = 1'b0;
        pop_master   = 1'b0;
        pop_slave    = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_reset(input int base);
        resetn = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        wr_k = base;
        rd_k = base;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        fetch_valid0 = 1'b0; fetch_valid1 = 1'b0; flush = 1'b0;
        pop_master = 1'b0; pop_slave = 1'b0;
        fetch_pc0 = '0; fetch_pc1 = '0; fetch_inst0 = '0; fetch_inst1 = '0;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_mvalid", 32'(master_valid), 32'd0);
        check("rst_svalid", 32'(slave_valid), 32'd0);
        check("rst_stall", 32'(full_stall), 32'd0);
        check("rst_mpc", master_pc, 32'h0);
        check("rst_sinst", slave_inst, 32'h0);
        check("rst_perf_full", perf_full_cycles, 32'h0);
        check("rst_perf_empty", perf_empty_cycles, 32'h0);
        resetn = 1'b1;

        // Idle empty cycles feed the empty-cycle counter when it is built.
        for (int i = 0; i < 5; i++) drive(0, 1'b0, 1'b0, 1'b0);
`ifdef INST_FIFO_PERF_CNT_EN
        check("perf_empty5", perf_empty_cycles, 32'd5);
`else
        check("perf_empty_off", perf_empty_cycles, 32'd0);
`endif
        check("perf_full_idle", perf_full_cycles, 32'd0);

        // First pair push.
        drive(2, 1'b0, 1'b0, 1'b0); wr_k += 2;
        check("pair_count", 32'(count), 32'd2);
        check("pair_mvalid", 32'(master_valid), 32'd1);
        check("pair_svalid", 32'(slave_valid), 32'd1);
        check("pair_mpc", master_pc, 32'h100);
        check("pair_minst", master_inst, 32'hA);
        check("pair_spc", slave_pc, 32'h104);
        check("pair_sinst", slave_inst, 32'hB);

        // Fill to 15 -> stall; a further pair is dropped.
        drive(1, 1'b0, 1'b0, 1'b0); wr_k += 1;
        for (int i = 0; i < 6; i++) begin
            drive(2, 1'b0, 1'b0, 1'b0); wr_k += 2;
        end
        check("fill_count", 32'(count), 32'd15);
        check("fill_stall", 32'(full_stall), 32'd1);
        drive(2, 1'b0, 1'b0, 1'b0);
        check("drop_count", 32'(count), 32'd15);
        check("drop_mpc", master_pc, pc_of(0));

        // Dual pop leaves 13, stall released.
        drive(0, 1'b1, 1'b1, 1'b0); rd_k += 2;
        check("dpop_count", 32'(count), 32'd13);
        check("dpop_stall", 32'(full_stall), 32'd0);
        check("dpop_mpc", master_pc, pc_of(rd_k));
        check("dpop_sinst", slave_inst, inst_of(rd_k + 1));

        // Push two, pop one in the same cycle.
        drive(2, 1'b1, 1'b0, 1'b0); rd_k += 1; wr_k += 2;
        check("pushpop_count", 32'(count), 32'd14);
        check("pushpop_mpc", master_pc, pc_of(rd_k));

        // Single entry: pop_slave ignored, then pop on empty.
        do_reset(100);
        fetch_valid0 = 1'b0;
        fetch_valid1 = 1'b1;
        @(posedge clk); #1;
        fetch_valid1 = 1'b0;
        check("v1_only_count", 32'(count), 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0); wr_k += 1;
        check("one_count", 32'(count), 32'd1);
        check("one_svalid", 32'(slave_valid), 32'd0);
        check("one_spc_zero", slave_pc, 32'h0);
        check("one_mpc", master_pc, pc_of(100));
        drive(0, 1'b1, 1'b1, 1'b0); rd_k += 1;
        check("one_pop_count", 32'(count), 32'd0);
        check("one_pop_mvalid", 32'(master_valid), 32'd0);
        drive(0, 1'b1, 1'b1, 1'b0);
        check("empty_pop_count", 32'(count), 32'd0);

        // Wrap: tail at 15, pop 2 while pushing 2 into slots 15 and 0.
        do_reset(200);
        drive(1, 1'b0, 1'b0, 1'b0); wr_k += 1;
        for (int i = 0; i < 7; i++) begin
            drive(2, 1'b0, 1'b0, 1'b0); wr_k += 2;
        end
        drive(0, 1'b1, 1'b0, 1'b0); rd_k += 1;
        check("wrap_pre_count", 32'(count), 32'd14);
        drive(2, 1'b1, 1'b1, 1'b0); rd_k += 2; wr_k += 2;
        check("wrap_count", 32'(count), 32'd14);
        check("wrap_stall", 32'(full_stall), 32'd0);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("wrap_drain_mpc%0d", i), master_pc, pc_of(rd_k));
            check($sformatf("wrap_drain_sinst%0d", i), slave_inst, inst_of(rd_k + 1));
            drive(0, 1'b1, 1'b1, 1'b0); rd_k += 2;
        end
        check("wrap_empty", 32'(count), 32'd0);

        // Flush overrides simultaneous push and pop.
        do_reset(300);
        for (int i = 0; i < 4; i++) begin
            drive(2, 1'b0, 1'b0, 1'b0); wr_k += 2;
        end
        check("flush_pre_count", 32'(count), 32'd8);
        drive(2, 1'b1, 1'b1, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_mvalid", 32'(master_valid), 32'd0);
        wr_k = 400; rd_k = 400;
        drive(2, 1'b0, 1'b0, 1'b0); wr_k += 2;
        check("postflush_mpc", master_pc, pc_of(400));
        check("postflush_sinst", slave_inst, inst_of(401));

        // Reset dominates flush, push and pop.
        for (int i = 0; i < 3; i++) begin
            drive(2, 1'b0, 1'b0, 1'b0); wr_k += 2;
        end
        check("rst8_pre_count", 32'(count), 32'd8);
        resetn = 1'b0;
        drive(2, 1'b1, 1'b1, 1'b1);
        resetn = 1'b1;
        check("rst8_count", 32'(count), 32'd0);
        check("rst8_mvalid", 32'(master_valid), 32'd0);
        check("rst8_mpc", master_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
